// File: rtl/abft_checksum_checker_if.sv
// Streaming bus for the ABFT checksum checker: control, beat handshake, data and results.
interface abft_checksum_checker_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned PW  = 16,
    parameter int unsigned LW  = 4,
    parameter int unsigned CW  = 32,
    parameter int unsigned ECW = 8
);
    logic            start;
    logic [LW-1:0]   len;
    logic            inject;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_vec;
    logic [N*DW-1:0] b_vec;
    logic [N*PW-1:0] p_vec;
    logic            busy;
    logic            done;
    logic            error;
    logic [ECW-1:0]  err_count;
    logic [CW-1:0]   mac_sum;
    logic [CW-1:0]   ref_sum;

    modport master (
        output start, len, inject, in_valid, a_vec, b_vec, p_vec,
        input  in_ready, busy, done, error, err_count, mac_sum, ref_sum
    );

    modport slave (
        input  start, len, inject, in_valid, a_vec, b_vec, p_vec,
        output in_ready, busy, done, error, err_count, mac_sum, ref_sum
    );
endinterface

// File: rtl/abft_checksum_checker.sv
// ABFT checker for C = A*B: accumulates per-channel sums of A, B and C over a streamed
// transaction, then compares sum_k colsumA[k]*rowsumB[k] with the total of C.
module abft_checksum_checker #(
    parameter int unsigned N   = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned PW  = 16,
    parameter int unsigned LW  = 4,
    parameter int unsigned CW  = 32,
    parameter int unsigned ECW = 8
) (
    input logic                    clk,
    input logic                    rst,
    abft_checksum_checker_if.slave bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StAcc, StChk, StCmp} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   sa_q [N];
    logic [CW-1:0]   sa_d [N];
    logic [CW-1:0]   sb_q [N];
    logic [CW-1:0]   sb_d [N];
    logic [CW-1:0]   sp_q [N];
    logic [CW-1:0]   sp_d [N];
    logic [LW-1:0]   beat_q, beat_d;
    logic [LW-1:0]   len_q, len_d;
    logic            inject_q, inject_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   mac_q, mac_d;
    logic [CW-1:0]   ref_q, ref_d;
    logic [CW-1:0]   mac_sum_q, mac_sum_d;
    logic [CW-1:0]   ref_sum_q, ref_sum_d;
    logic            error_q, error_d;
    logic [ECW-1:0]  err_count_q, err_count_d;
    logic            done_q, done_d;
    logic [CW-1:0]   prod;
    logic [CW-1:0]   ref_f;

    // Product is truncated to CW, matching the modulo arithmetic of the C path.
    assign prod  = sa_q[idx_q] * sb_q[idx_q];
    assign ref_f = ref_q ^ CW'(inject_q);

    // Next-state and datapath updates for the IDLE/ACC/CHK/CMP sequence.
    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        sp_d        = sp_q;
        beat_d      = beat_q;
        len_d       = len_q;
        inject_d    = inject_q;
        idx_d       = idx_q;
        mac_d       = mac_q;
        ref_d       = ref_q;
        mac_sum_d   = mac_sum_q;
        ref_sum_d   = ref_sum_q;
        error_d     = error_q;
        err_count_d = err_count_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // done_q high means CMP just finished; a start in that cycle is dropped.
                if (bus.start && !done_q) begin
                    for (int k = 0; k < N; k++) begin
                        sa_d[k] = '0;
                        sb_d[k] = '0;
                        sp_d[k] = '0;
                    end
                    beat_d   = '0;
                    idx_d    = '0;
                    mac_d    = '0;
                    ref_d    = '0;
                    len_d    = bus.len;
                    inject_d = bus.inject;
                    state_d  = (bus.len == '0) ? StChk : StAcc;
                end
            end
            StAcc: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < N; k++) begin
                        sa_d[k] = sa_q[k] + CW'(bus.a_vec[k*DW +: DW]);
                        sb_d[k] = sb_q[k] + CW'(bus.b_vec[k*DW +: DW]);
                        sp_d[k] = sp_q[k] + CW'(bus.p_vec[k*PW +: PW]);
                    end
                    beat_d = beat_q + LW'(1);
                    if (beat_q + LW'(1) == len_q) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                mac_d = mac_q + prod;
                ref_d = ref_q + sp_q[idx_q];
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                mac_sum_d = mac_q;
                ref_sum_d = ref_f;
                error_d   = (mac_q != ref_f);
                if ((mac_q != ref_f) && (err_count_q != '1)) begin
                    err_count_d = err_count_q + ECW'(1);
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sa_q        <= '{default: '0};
            sb_q        <= '{default: '0};
            sp_q        <= '{default: '0};
            beat_q      <= '0;
            len_q       <= '0;
            inject_q    <= 1'b0;
            idx_q       <= '0;
            mac_q       <= '0;
            ref_q       <= '0;
            mac_sum_q   <= '0;
            ref_sum_q   <= '0;
            error_q     <= 1'b0;
            err_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sp_q        <= sp_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            inject_q    <= inject_d;
            idx_q       <= idx_d;
            mac_q       <= mac_d;
            ref_q       <= ref_d;
            mac_sum_q   <= mac_sum_d;
            ref_sum_q   <= ref_sum_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == StAcc);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.err_count = err_count_q;
    assign bus.mac_sum   = mac_sum_q;
    assign bus.ref_sum   = ref_sum_q;
endmodule
